// File: rtl/shared_signed_adder_sched_pkg.sv
// Shared defaults and the requester id type for the shared signed-adder scheduler.
package adder_sched_pkg;
    localparam int DEF_W     = 4;
    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 8;

    typedef logic [$clog2(DEF_N)-1:0] id_t;
endpackage

// File: rtl/shared_signed_adder_sched_if.sv
// Requester-side operand handshake plus the single backpressured result port.
interface shared_signed_adder_sched_if
    import adder_sched_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_overflow;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow
    );
endinterface

// File: rtl/shared_signed_adder_sched_arb.sv
// Stateless round-robin pick: first requester found scanning ptr, ptr+1, ... wrapping at N.
module round_robin_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);
    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                any_grant  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_signed_adder_sched.sv
// N requesters share one W-bit signed adder; round-robin grant into a single
// backpressured result register, plus a saturating overflow event counter.
module shared_signed_adder_sched
    import adder_sched_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    shared_signed_adder_sched_if.slave  bus,
    output logic [CNT_W-1:0]            ovf_count
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [N-1:0]  arb_req;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic          xfer;
    logic          slot_free;
    logic [W-1:0]  op_a, op_b, sum;
    logic          ovf;

    // Only offer a grant when the result slot will be empty next cycle; the
    // reset gate keeps req_ready low while rst is held.
    assign slot_free = !bus.rsp_valid || bus.rsp_ready;
    assign arb_req   = (slot_free && !rst) ? bus.req_valid : '0;

    round_robin_arbiter #(.N(N), .IW(IW)) u_arb (
        .req       (arb_req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx),
        .any_grant (xfer)
    );

    assign bus.req_ready = grant;

    assign op_a = bus.req_a[gidx*W +: W];
    assign op_b = bus.req_b[gidx*W +: W];
    assign sum  = op_a + op_b;
    assign ovf  = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr              <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_sum      <= '0;
            bus.rsp_overflow <= 1'b0;
            ovf_count        <= '0;
        end else begin
            if (xfer) begin
                ptr              <= (gidx == IW'(N-1)) ? '0 : gidx + IW'(1);
                bus.rsp_valid    <= 1'b1;
                bus.rsp_id       <= gidx;
                bus.rsp_sum      <= sum;
                bus.rsp_overflow <= ovf;
            end else if (bus.rsp_ready) begin
                bus.rsp_valid    <= 1'b0;
            end
            if (xfer && ovf && (ovf_count != '1))
                ovf_count <= ovf_count + CNT_W'(1);
        end
    end
endmodule

// File: doc/shared_signed_adder_sched.md
# shared_signed_adder_sched

Round-robin scheduler that shares one W-bit two's-complement adder with overflow detection among N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the wrapped sum and the signed-overflow flag, and returns the result tagged with the requester id through a single backpressured output register. It sits between the arithmetic-exercise clients and the shared add datapath, and also keeps a saturating count of overflow events.

## Interface
Parameters:
- W, 4 — operand/sum width (two's complement), W ≥ 2
- N, 4 — number of requesters, N ≥ 2
- CNT_W, 8 — width of overflow event counter

Ports:
- clk  in  1  — the single clock
- rst  in  1  — asynchronous, active-high reset
- req_valid  in  N  — requester i has an operand pair
- req_ready  out  N  — one-hot grant; transfer on req_valid[i] & req_ready[i]
- req_a  in  N*W  — operand A; requester i at bits [i*W +: W]
- req_b  in  N*W  — operand B; same packing
- rsp_valid  out  1  — result register holds a result
- rsp_ready  in  1  — consumer accepts the result
- rsp_id  out  $clog2(N)  — index of the requester that produced the result
- rsp_sum  out  W  — (a + b) mod 2^W
- rsp_overflow  out  1  — signed overflow of that addition
- ovf_count  out  CNT_W  — saturating count of accepted operations with overflow

## Operation
- Slot free: `slot_free = !rsp_valid | rsp_ready`.
- Grant:
  - When slot_free and any req_valid, assert req_ready for exactly one valid requester, chosen round-robin.
  - Otherwise req_ready = 0.
  - req_ready is combinational from req_valid, the pointer and rsp state; it never depends on rsp_sum.
- Round-robin:
  - Priority pointer `ptr`. The search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - After a transfer from requester g, ptr ← (g+1) mod N.
  - ptr is unchanged on idle cycles.
- Arithmetic:
  - sum = low W bits of a + b.
  - overflow = (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1]).
  - Examples at W=4: 4+7 → sum 4'b1011, ovf 1. −4+−4 → 4'b1000, ovf 0. −3+−6 → 4'b0111, ovf 1.
- Output register:
  - On a transfer, load rsp_id, rsp_sum and rsp_overflow, and set rsp_valid.
  - On rsp_valid & rsp_ready with no new transfer, clear rsp_valid.
  - When rsp_valid & !rsp_ready, all rsp_* hold stable and no grant is issued.
- ovf_count increments by 1 on each transfer whose computed overflow = 1. It saturates at 2^CNT_W − 1 and never wraps.
- Requester side: once req_valid[i] is asserted, it must hold stable until granted. The block does not check this.

## Timing
- Reset (async assert, sync deassert by the environment) sets: rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_overflow 0, ovf_count 0, ptr 0.
- During reset, req_ready = 0.
- Latency: a transfer at edge t makes the result visible with rsp_valid = 1 after edge t (the next cycle).
- Throughput: one operation per cycle while rsp_ready = 1.
- Simultaneous drain and load: if rsp_valid & rsp_ready and a new transfer occur in the same cycle, the new result replaces the old one and rsp_valid stays 1.
- All requesters valid: each requester is granted exactly once in any N consecutive grant cycles.
- Single requester valid: it is granted every free cycle regardless of ptr.
- Reset mid-operation: any held result is discarded and ptr returns to 0. A request outstanding at reset is not considered taken.

## Structure
- Shared package `adder_sched_pkg`: default W, N and CNT_W localparams, and the `id_t` typedef (logic [$clog2(N)-1:0]).
- Sub-module `round_robin_arbiter` (params N), purely combinational:
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant[N], grant index, any_grant.
  - It holds no state; ptr lives in the top.
- The adder and overflow logic are inline in the top.

## Test plan
1. **Reset:** assert rst with all req_valid = 1. Check all outputs are 0 and req_ready = 0. Release rst: requester 0 is granted first.
2. **Single requester, W=4:** requester 2 sends (4,7), then (−4,−4), then (1,−2), with rsp_ready = 1. Expected responses: id 2, sum 4'b1011 ovf 1; sum 4'b1000 ovf 0; sum 4'b1111 ovf 0. Each appears one cycle after its transfer. ovf_count = 1.
3. **Fairness:** all four requesters valid continuously for 8 grant cycles. Grant order is 0,1,2,3,0,1,2,3 and rsp_id follows the same sequence.
4. **Backpressure:** hold rsp_ready = 0 for 3 cycles while a result is valid. Check that rsp_* stay stable and req_ready = 0. On release, the drain and a new load happen in the same cycle, and there is no bubble.
5. **Counter saturation (CNT_W=2):** issue 5 overflowing adds of (−3,−6). ovf_count reads 1,2,3,3,3.
6. **Reset mid-stream:** assert rst while rsp_valid = 1 and ptr = 2. Check rsp_valid drops at once. After release, requester 0 has priority.
